// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the shared UART TX byte FIFO.
// A grant is held until the owner's last byte, an idle timeout, or the length cap.
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int MAX_PKT_LEN = 64,
  parameter int IDLE_TMO    = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enable_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_last_i,
  output logic [N_REQ-1:0]   req_ready_o,
  input  logic               tx_fifo_full_i,
  output logic               tx_fifo_wr_en_o,
  output logic [7:0]         tx_fifo_data_o,
  output logic [N_REQ-1:0]   grant_o,
  output logic               busy_o,
  output logic               timeout_o,
  output logic               trunc_o
);

  localparam int          IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int          BCW  = $clog2(MAX_PKT_LEN + 1);
  localparam int          ICW  = $clog2(IDLE_TMO + 1);
  localparam int unsigned NU   = N_REQ;

  typedef enum logic [0:0] {S_IDLE, S_XFER} state_t;

  state_t            state_q;
  logic [N_REQ-1:0]  grant_q;
  logic [IDXW-1:0]   owner_q;
  logic [IDXW-1:0]   rr_ptr_q;
  logic [BCW-1:0]    byte_cnt_q;
  logic [ICW-1:0]    idle_cnt_q;
  logic              timeout_q;
  logic              trunc_q;

  logic [IDXW-1:0]   cand;
  logic [IDXW-1:0]   win_idx;
  logic              win_found;
  logic              xfer;
  logic              owner_valid;
  logic              owner_last;
  logic              ready_own;
  logic              accept;

  // Search starts just after the previous winner so it gets lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NU; i++) begin
      cand = IDXW'((32'(rr_ptr_q) + i) % NU);
      if (!win_found && req_valid_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    xfer            = (state_q == S_XFER);
    owner_valid     = req_valid_i[owner_q];
    owner_last      = req_last_i[owner_q];
    ready_own       = xfer & enable_i & ~tx_fifo_full_i & ~rst_i;
    accept          = ready_own & owner_valid;
    req_ready_o     = ready_own ? grant_q : '0;
    tx_fifo_wr_en_o = accept;
    tx_fifo_data_o  = xfer ? req_data_i[{owner_q, 3'b000} +: 8] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= IDXW'(N_REQ - 1);
      byte_cnt_q <= '0;
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
      trunc_q    <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      trunc_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enable_i && win_found) begin
            grant_q    <= N_REQ'(1) << win_idx;
            owner_q    <= win_idx;
            rr_ptr_q   <= win_idx;
            byte_cnt_q <= '0;
            idle_cnt_q <= '0;
            state_q    <= S_XFER;
          end
        end
        S_XFER: begin
          if (accept) begin
            byte_cnt_q <= byte_cnt_q + 1'b1;
            idle_cnt_q <= '0;
            // Last wins over the length cap when both land on the same byte.
            if (owner_last) begin
              grant_q <= '0;
              state_q <= S_IDLE;
            end else if (byte_cnt_q == BCW'(MAX_PKT_LEN - 1)) begin
              trunc_q <= 1'b1;
              grant_q <= '0;
              state_q <= S_IDLE;
            end
          end else if (enable_i && !owner_valid) begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
            if (idle_cnt_q == ICW'(IDLE_TMO - 1)) begin
              timeout_q <= 1'b1;
              grant_q   <= '0;
              state_q   <= S_IDLE;
            end
          end
        end
        default: begin
          grant_q <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign grant_o   = grant_q;
  assign busy_o    = xfer;
  assign timeout_o = timeout_q;
  assign trunc_o   = trunc_q;

endmodule
